scorehand_seq: RTL and testbench

- Sequential, multi-hand successor to the combinational three-card scorer.
- Accepts cards one at a time over a valid/ready stream and routes each card to a selected hand.
- Keeps a registered running baccarat score (mod 10) per hand, plus card count, full flag and natural flag.
- Sits between the card dealer and the baccarat decision state machine, replacing the per-hand combinational scorers.

---
 rtl/scorehand_seq.sv | 149 ++++++++++++++
 tb/tb_scorehand_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scorehand_seq.sv
// scorehand_seq
// Multi-hand running baccarat scorer. Cards arrive one at a time over a
// valid/ready stream and each card is routed to the hand named by card_hand.
// Every hand keeps a registered score (mod 10), a card count, a full flag and
// a natural flag. All per-hand outputs are registered (latency 1).
//
// Ports:
//   slow_clock  sole clock, rising edge
//   resetb      asynchronous active-low reset
//   clear       synchronous clear of all hands
//   card_valid  card_hand / card_value valid this cycle
//   card_ready  block accepts a card this cycle (low while clear or in reset)
//   card_hand   target hand index
//   card_value  1 = A, 2..9 pips, 10..13 = 10/J/Q/K; 0, 14, 15 illegal
//   totals      per-hand score, hand i at [4i+3:4i]
//   counts      per-hand accepted card count, hand i at [CW*i +: CW]
//   full        hand i accepts no more cards
//   natural     hand i scored 8 or 9 on exactly two cards
//   err         one-cycle pulse after a rejected transfer
module scorehand_seq #(
    parameter int NUM_HANDS = 2,
    parameter int MAX_CARDS = 3,
    localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
    localparam int CW = $clog2(MAX_CARDS + 1)
) (
    input  logic                    slow_clock,
    input  logic                    resetb,
    input  logic                    clear,
    input  logic                    card_valid,
    output logic                    card_ready,
    input  logic [HW-1:0]           card_hand,
    input  logic [3:0]              card_value,
    output logic [4*NUM_HANDS-1:0]  totals,
    output logic [CW*NUM_HANDS-1:0] counts,
    output logic [NUM_HANDS-1:0]    full,
    output logic [NUM_HANDS-1:0]    natural,
    output logic                    err
);

    // Per-hand state, derived from count and full flag
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic                 ready_q;
    logic                 transfer;
    logic                 value_legal;
    logic [3:0]           value_pts;
    logic [NUM_HANDS-1:0] accept;
    logic                 err_q;

    // ready_q holds card_ready low during reset and until the first edge after
    // release; afterwards only clear can drop card_ready.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign card_ready = ready_q & ~clear;
    assign transfer   = card_valid & card_ready;

    // Card code to baccarat points; face cards and tens score zero.
    always_comb begin
        value_legal = 1'b0;
        value_pts   = 4'd0;
        if (card_value >= 4'd1 && card_value <= 4'd9) begin
            value_legal = 1'b1;
            value_pts   = card_value;
        end else if (card_value >= 4'd10 && card_value <= 4'd13) begin
            value_legal = 1'b1;
            value_pts   = 4'd0;
        end
    end

    for (genvar i = 0; i < NUM_HANDS; i++) begin : g_hand
        logic [3:0]    total_q;
        logic [CW-1:0] count_q;
        logic          full_q;
        logic          natural_q;
        logic [1:0]    state;
        logic [4:0]    sum;
        logic [3:0]    total_next;
        logic [CW-1:0] count_next;

        // An out-of-range card_hand matches no hand, so it is rejected for free.
        assign accept[i] = transfer & value_legal & (card_hand == HW'(i)) & ~full_q;

        assign state = full_q ? ST_LOCKED :
                       (count_q == '0) ? ST_EMPTY : ST_PARTIAL;

        // Sum is at most 9 + 9 = 18, so one conditional subtract gives mod 10.
        assign sum        = {1'b0, total_q} + {1'b0, value_pts};
        assign total_next = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
        assign count_next = count_q + CW'(1);

        // Natural is judged only on the card that brings the count to two.
        always_ff @(posedge slow_clock or negedge resetb) begin
            if (!resetb) begin
                total_q   <= 4'd0;
                count_q   <= '0;
                full_q    <= 1'b0;
                natural_q <= 1'b0;
            end else if (clear) begin
                total_q   <= 4'd0;
                count_q   <= '0;
                full_q    <= 1'b0;
                natural_q <= 1'b0;
            end else if (accept[i]) begin
                case (state)
                    ST_EMPTY, ST_PARTIAL: begin
                        total_q <= total_next;
                        count_q <= count_next;
                        if (count_next == CW'(MAX_CARDS)) begin
                            full_q <= 1'b1;
                        end
                        if (count_next == CW'(2) && total_next >= 4'd8) begin
                            full_q    <= 1'b1;
                            natural_q <= 1'b1;
                        end
                    end
                    default: begin
                        total_q <= total_q;
                    end
                endcase
            end
        end

        assign totals[4*i +: 4]   = total_q;
        assign counts[CW*i +: CW] = count_q;
        assign full[i]            = full_q;
        assign natural[i]         = natural_q;
    end

    // A transfer that no hand accepted is a rejection. Clear forces
    // card_ready low, so a clear edge never reports an error.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            err_q <= 1'b0;
        end else begin
            err_q <= transfer & ~(|accept);
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_scorehand_seq.sv
// tb_scorehand_seq
// Scoreboard bench for scorehand_seq. Three instances are exercised:
//   A: NUM_HANDS = 2, MAX_CARDS = 3 (player / banker default)
//   B: NUM_HANDS = 4, MAX_CARDS = 5
//   C: NUM_HANDS = 3, MAX_CARDS = 2 (out-of-range hand index reachable)
// Stimulus tasks push hand-computed snapshots into a queue; a monitor on the
// falling edge pops one entry for every edge that carried a card or a clear.
module tb_scorehand_seq;

    logic slow_clock = 1'b0;
    logic resetb;
    logic clear;

    logic        valid_a, ready_a, err_a;
    logic [0:0]  hand_a;
    logic [3:0]  value_a;
    logic [7:0]  totals_a;
    logic [3:0]  counts_a;
    logic [1:0]  full_a, natural_a;

    logic        valid_b, ready_b, err_b;
    logic [1:0]  hand_b;
    logic [3:0]  value_b;
    logic [15:0] totals_b;
    logic [11:0] counts_b;
    logic [3:0]  full_b, natural_b;

    logic        valid_c, ready_c, err_c;
    logic [1:0]  hand_c;
    logic [3:0]  value_c;
    logic [11:0] totals_c;
    logic [5:0]  counts_c;
    logic [2:0]  full_c, natural_c;

    scorehand_seq #(.NUM_HANDS(2), .MAX_CARDS(3)) dut_a (
        .slow_clock(slow_clock), .resetb(resetb), .clear(clear),
        .card_valid(valid_a), .card_ready(ready_a), .card_hand(hand_a),
        .card_value(value_a), .totals(totals_a), .counts(counts_a),
        .full(full_a), .natural(natural_a), .err(err_a)
    );

    scorehand_seq #(.NUM_HANDS(4), .MAX_CARDS(5)) dut_b (
        .slow_clock(slow_clock), .resetb(resetb), .clear(clear),
        .card_valid(valid_b), .card_ready(ready_b), .card_hand(hand_b),
        .card_value(value_b), .totals(totals_b), .counts(counts_b),
        .full(full_b), .natural(natural_b), .err(err_b)
    );

    scorehand_seq #(.NUM_HANDS(3), .MAX_CARDS(2)) dut_c (
        .slow_clock(slow_clock), .resetb(resetb), .clear(clear),
        .card_valid(valid_c), .card_ready(ready_c), .card_hand(hand_c),
        .card_value(value_c), .totals(totals_c), .counts(counts_c),
        .full(full_c), .natural(natural_c), .err(err_c)
    );

    initial forever #5 slow_clock = ~slow_clock;

    typedef struct {
        int          which;
        logic [15:0] totals;
        logic [11:0] counts;
        logic [3:0]  full;
        logic [3:0]  nat;
        logic        err;
        string       name;
    } exp_t;

    exp_t expq[$];

    logic [15:0] snap_tot  [3];
    logic [11:0] snap_cnt  [3];
    logic [3:0]  snap_full [3];
    logic [3:0]  snap_nat  [3];

    int tests_run    = 0;
    int tests_failed = 0;
    bit pending      = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic zeroSnapshots();
        for (int w = 0; w < 3; w++) begin
            snap_tot[w]  = '0;
            snap_cnt[w]  = '0;
            snap_full[w] = '0;
            snap_nat[w]  = '0;
        end
    endtask

    task automatic pushExpected(input int which, input logic err_exp, input string name);
        exp_t e;
        e.which  = which;
        e.totals = snap_tot[which];
        e.counts = snap_cnt[which];
        e.full   = snap_full[which];
        e.nat    = snap_nat[which];
        e.err    = err_exp;
        e.name   = name;
        expq.push_back(e);
    endtask

    // Drives the card inputs of one instance and idles the other two.
    task automatic driveCard(input int which, input bit v, input int hand, input int value);
        valid_a = (which == 0) && v;
        valid_b = (which == 1) && v;
        valid_c = (which == 2) && v;
        hand_a  = 1'(hand);
        hand_b  = 2'(hand);
        hand_c  = 2'(hand);
        value_a = 4'(value);
        value_b = 4'(value);
        value_c = 4'(value);
    endtask

    // Accepted card with the hand-computed resulting state of the target hand.
    task automatic applyStimulus(input int which, input int hand, input int value,
                                 input int exp_tot, input int exp_cnt,
                                 input bit exp_full, input bit exp_nat, input string name);
        @(posedge slow_clock);
        #1;
        clear = 1'b0;
        driveCard(which, 1'b1, hand, value);
        snap_tot[which][4*hand +: 4] = 4'(exp_tot);
        if (which == 1) snap_cnt[which][3*hand +: 3] = 3'(exp_cnt);
        else            snap_cnt[which][2*hand +: 2] = 2'(exp_cnt);
        snap_full[which][hand] = exp_full;
        snap_nat[which][hand]  = exp_nat;
        pushExpected(which, 1'b0, name);
    endtask

    // Card that must be rejected: every hand unchanged, err pulses.
    task automatic applyReject(input int which, input int hand, input int value,
                               input string name);
        @(posedge slow_clock);
        #1;
        clear = 1'b0;
        driveCard(which, 1'b1, hand, value);
        pushExpected(which, 1'b1, name);
    endtask

    task automatic applyIdle();
        @(posedge slow_clock);
        #1;
        clear = 1'b0;
        driveCard(0, 1'b0, 0, 0);
    endtask

    // Clear, optionally colliding with a card on instance A hand 0.
    task automatic applyClear(input bit with_card, input string name);
        @(posedge slow_clock);
        #1;
        clear = 1'b1;
        driveCard(0, with_card, 0, 5);
        #1;
        checkOutput({name, "_ready_a"}, 32'(ready_a), 32'd0);
        zeroSnapshots();
        pushExpected(0, 1'b0, name);
    endtask

    task automatic checkErrLow(input string name);
        @(posedge slow_clock);
        @(negedge slow_clock);
        checkOutput(name, 32'({err_c, err_b, err_a}), 32'd0);
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, "_tot_a"},   32'(totals_a), 32'd0);
        checkOutput({name, "_cnt_a"},   32'(counts_a), 32'd0);
        checkOutput({name, "_flags_a"}, 32'({full_a, natural_a, err_a}), 32'd0);
        checkOutput({name, "_tot_b"},   32'(totals_b), 32'd0);
        checkOutput({name, "_cnt_b"},   32'(counts_b), 32'd0);
        checkOutput({name, "_flags_b"}, 32'({full_b, natural_b, err_b}), 32'd0);
        checkOutput({name, "_tot_c"},   32'(totals_c), 32'd0);
        checkOutput({name, "_cnt_c"},   32'(counts_c), 32'd0);
        checkOutput({name, "_flags_c"}, 32'({full_c, natural_c, err_c}), 32'd0);
        checkOutput({name, "_ready"},   32'({ready_c, ready_b, ready_a}), 32'd0);
    endtask

    // Monitor: compares the outputs produced by the previous edge's event,
    // then notes whether the coming edge carries a card or a clear.
    always @(negedge slow_clock) begin : monitor
        exp_t        e;
        logic [15:0] act_tot;
        logic [11:0] act_cnt;
        logic [3:0]  act_full;
        logic [3:0]  act_nat;
        logic        act_err;
        if (pending) begin
            if (expq.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL scoreboard_empty: actual event with no expectation");
            end else begin
                e = expq.pop_front();
                case (e.which)
                    0: begin
                        act_tot = {8'd0, totals_a}; act_cnt = {8'd0, counts_a};
                        act_full = {2'd0, full_a}; act_nat = {2'd0, natural_a}; act_err = err_a;
                    end
                    1: begin
                        act_tot = totals_b; act_cnt = counts_b;
                        act_full = full_b; act_nat = natural_b; act_err = err_b;
                    end
                    default: begin
                        act_tot = {4'd0, totals_c}; act_cnt = {6'd0, counts_c};
                        act_full = {1'b0, full_c}; act_nat = {1'b0, natural_c}; act_err = err_c;
                    end
                endcase
                checkOutput({e.name, "_totals"},  32'(act_tot),  32'(e.totals));
                checkOutput({e.name, "_counts"},  32'(act_cnt),  32'(e.counts));
                checkOutput({e.name, "_full"},    32'(act_full), 32'(e.full));
                checkOutput({e.name, "_natural"}, 32'(act_nat),  32'(e.nat));
                checkOutput({e.name, "_err"},     32'(act_err),  32'(e.err));
            end
        end
        pending = resetb && ((valid_a && ready_a) || (valid_b && ready_b) ||
                             (valid_c && ready_c) || clear);
    end

    initial begin
        resetb = 1'b0;
        clear  = 1'b0;
        driveCard(0, 1'b0, 0, 0);
        zeroSnapshots();
        #2;
        checkResetState("reset");
        #10;
        resetb = 1'b1;
        #1;
        checkOutput("ready_before_edge", 32'(ready_a), 32'd0);
        @(posedge slow_clock);
        #1;
        checkOutput("ready_after_edge", 32'({ready_c, ready_b, ready_a}), 32'd7);

        // Single hand, back to back
        applyStimulus(0, 0, 2, 2, 1, 0, 0, "h0_c2");
        applyStimulus(0, 0, 3, 5, 2, 0, 0, "h0_c3");
        applyStimulus(0, 0, 4, 9, 3, 1, 0, "h0_c4");
        // Face cards on hand 1
        applyStimulus(0, 1, 10, 0, 1, 0, 0, "h1_c10");
        applyStimulus(0, 1, 11, 0, 2, 0, 0, "h1_c11");
        applyStimulus(0, 1, 12, 0, 3, 1, 0, "h1_c12");
        applyReject(0, 0, 5, "h0_full_rej");
        applyClear(1'b0, "clear1");
        // Wrap past ten
        applyStimulus(0, 0, 7, 7, 1, 0, 0, "wrap_c7");
        applyStimulus(0, 0, 8, 5, 2, 0, 0, "wrap_c8");
        applyStimulus(0, 0, 9, 4, 3, 1, 0, "wrap_c9");
        applyClear(1'b0, "clear2");
        // Natural nine with a face card
        applyStimulus(0, 0, 9, 9, 1, 0, 0, "nat9_c9");
        applyStimulus(0, 0, 10, 9, 2, 1, 1, "nat9_c10");
        applyClear(1'b0, "clear3");
        // Natural eight locks the hand
        applyStimulus(0, 0, 4, 4, 1, 0, 0, "nat8_c4a");
        applyStimulus(0, 0, 4, 8, 2, 1, 1, "nat8_c4b");
        applyReject(0, 0, 5, "nat8_third_rej");
        // Hand 1 independent of locked hand 0; 13 scores zero
        applyStimulus(0, 1, 5, 5, 1, 0, 0, "h1_c5");
        applyStimulus(0, 1, 13, 5, 2, 0, 0, "h1_c13");
        // Illegal codes
        applyReject(0, 1, 0, "illegal_0");
        applyReject(0, 1, 14, "illegal_14");
        applyReject(0, 1, 15, "illegal_15");
        applyIdle();
        checkErrLow("err_after_reject");
        // Clear colliding with a card
        applyClear(1'b0, "clear4");
        applyStimulus(0, 0, 3, 3, 1, 0, 0, "coll_c3");
        applyStimulus(0, 0, 4, 7, 2, 0, 0, "coll_c4");
        applyClear(1'b1, "clear_collide");
        applyStimulus(0, 0, 6, 6, 1, 0, 0, "coll_c6");

        // Instance C: three hands, two cards max, hand 3 out of range
        applyReject(2, 3, 4, "c_hand3_rej");
        applyStimulus(2, 2, 9, 9, 1, 0, 0, "c_h2_c9");
        applyStimulus(2, 2, 13, 9, 2, 1, 1, "c_h2_c13");
        applyStimulus(2, 1, 3, 3, 1, 0, 0, "c_h1_c3");
        applyStimulus(2, 1, 2, 5, 2, 1, 0, "c_h1_c2");
        applyReject(2, 1, 1, "c_h1_full_rej");

        // Instance B: four hands, five cards max
        applyStimulus(1, 3, 1, 1, 1, 0, 0, "b_h3_c1");
        applyStimulus(1, 3, 1, 2, 2, 0, 0, "b_h3_c2");
        applyStimulus(1, 3, 1, 3, 3, 0, 0, "b_h3_c3");
        applyStimulus(1, 3, 1, 4, 4, 0, 0, "b_h3_c4");
        applyStimulus(1, 3, 1, 5, 5, 1, 0, "b_h3_c5");
        applyReject(1, 3, 1, "b_h3_full_rej");
        applyStimulus(0, 0, 2, 8, 2, 1, 1, "pre_reset_a");
        applyIdle();

        // Asynchronous reset between edges with state in every instance
        @(posedge slow_clock);
        #3;
        resetb = 1'b0;
        #1;
        checkResetState("async_reset");
        zeroSnapshots();
        #3;
        resetb = 1'b1;
        @(posedge slow_clock);
        #1;
        checkOutput("ready_after_async", 32'({ready_c, ready_b, ready_a}), 32'd7);
        applyStimulus(0, 1, 6, 6, 1, 0, 0, "post_reset_h1");
        applyIdle();
        repeat (3) @(negedge slow_clock);

        tests_run++;
        if (expq.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: actual %0d left required 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
